// File: rtl/pipe_sched_pkg.sv
// Shared definitions for the pipeline scheduler / shared-RAM arbiter.
// Holds the pause bit positions, the scheduler state encoding, the RAM owner
// codes, the nop instruction word and the active-low reset level.
package pipe_sched_pkg;

    // Bit positions inside the 5-bit pause vector
    localparam int PausePc    = 0;
    localparam int PauseIfId  = 1;
    localparam int PauseIdEx  = 2;
    localparam int PauseExMem = 3;
    localparam int PauseMemWb = 4;
    localparam int PauseW     = 5;

    typedef enum logic [1:0] {
        SchIdle   = 2'd0,
        SchAccMem = 2'd1,
        SchAccIf  = 2'd2
    } sch_state_e;

    // RAM address/data mux select
    localparam logic OwnIf  = 1'b0;
    localparam logic OwnMem = 1'b1;

    // Instruction word loaded into ID/EX when a bubble is inserted
    localparam logic [15:0] NopIns = 16'h0800;

    localparam logic RstnEnable = 1'b0;

    // Whole pipeline frozen
    function automatic logic [PauseW-1:0] pause_all();
        return '1;
    endfunction

    // Load-use stall: only PC and IF/ID hold, the rest of the pipe moves on
    function automatic logic [PauseW-1:0] pause_load_use();
        logic [PauseW-1:0] p;
        p            = '0;
        p[PausePc]   = 1'b1;
        p[PauseIfId] = 1'b1;
        return p;
    endfunction

endpackage

// File: rtl/pipe_sched_if.sv
// Handshake bundle between the CPU pipeline and the scheduler.
//   master (pipeline side): drives if_req, mem_req, mem_we, load_use;
//                           receives pause, bubble_id_ex, RAM strobes, busy.
//   slave  (scheduler)    : the reverse directions.
interface pipe_sched_if;
    import pipe_sched_pkg::*;

    logic              if_req;
    logic              mem_req;
    logic              mem_we;
    logic              load_use;
    logic [PauseW-1:0] pause;
    logic              bubble_id_ex;
    logic              ram_owner;
    logic              ram_oe_n;
    logic              ram_we_n;
    logic              busy;

    modport master (
        output if_req, mem_req, mem_we, load_use,
        input  pause, bubble_id_ex, ram_owner, ram_oe_n, ram_we_n, busy
    );

    modport slave (
        input  if_req, mem_req, mem_we, load_use,
        output pause, bubble_id_ex, ram_owner, ram_oe_n, ram_we_n, busy
    );

endinterface

// File: rtl/pipe_sched_acc_timer.sv
// acc_timer: cycle counter for one SRAM access.
// Ports:
//   clk   in  system clock
//   rst   in  asynchronous active-low reset
//   clear in  restart the count at 0 on the next edge (has priority over run)
//   run   in  an access is in progress; count up
//   last  out final cycle of the current access (cnt == ACC_CYCLES-1 while running)
module acc_timer
    import pipe_sched_pkg::*;
#(
    parameter int ACC_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic last
);

    localparam logic [2:0] CntLast = 3'(ACC_CYCLES - 1);

    logic [2:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstnEnable) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= cnt + 3'd1;
        end
    end

    assign last = run && (cnt == CntLast);

endmodule

// File: rtl/pipe_sched.sv
// pipe_sched: pipeline step scheduler and shared-SRAM arbiter.
// One RAM access at a time (MEM before IF); the pipeline is frozen while an
// access is in flight and advances on the last cycle of the fetch. Load-use
// hazards hold PC and IF/ID and push a nop into ID/EX on that advance.
// Ports:
//   clk  in  system clock
//   rst  in  asynchronous active-low reset
//   bus  slave modport of pipe_sched_if (requests in; pause, bubble,
//        RAM owner / strobes and busy out)
// Outputs depend only on state, the access timer, we_q and load_use.
module pipe_sched
    import pipe_sched_pkg::*;
#(
    parameter int ACC_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst,
    pipe_sched_if.slave  bus
);

    localparam bit OneCycleAcc = (ACC_CYCLES == 1);

    sch_state_e state;
    logic       mem_done;
    logic       we_q;
    logic       last;
    logic       arb;
    logic       advance;
    logic       busy_int;

    assign busy_int = (state != SchIdle);
    // Arbitration happens while idle and at the end of each access; the
    // timer restarts at every such point, even when re-entering the same state.
    assign arb      = !busy_int || last;
    assign advance  = (state == SchAccIf) && last;

    acc_timer #(
        .ACC_CYCLES (ACC_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (arb),
        .run   (busy_int),
        .last  (last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstnEnable) begin
            state    <= SchIdle;
            mem_done <= 1'b0;
            we_q     <= 1'b0;
        end else begin
            // mem_done keeps a still-asserted mem_req from re-running the
            // same data access before the pipeline moves on.
            if ((state == SchAccMem) && last) begin
                mem_done <= 1'b1;
            end else if (advance) begin
                mem_done <= 1'b0;
            end

            if (arb) begin
                if (bus.mem_req && !mem_done && (state != SchAccMem)) begin
                    state <= SchAccMem;
                    we_q  <= bus.mem_we;
                end else if (bus.if_req) begin
                    state <= SchAccIf;
                end else begin
                    state <= SchIdle;
                end
            end
        end
    end

    always_comb begin
        bus.pause        = pause_all();
        bus.bubble_id_ex = 1'b0;
        bus.ram_owner    = OwnIf;
        bus.ram_oe_n     = 1'b1;
        bus.ram_we_n     = 1'b1;
        bus.busy         = busy_int;

        if (advance) begin
            if (bus.load_use) begin
                bus.pause        = pause_load_use();
                bus.bubble_id_ex = 1'b1;
            end else begin
                bus.pause        = '0;
            end
        end

        case (state)
            SchAccIf: begin
                bus.ram_oe_n = 1'b0;
            end
            SchAccMem: begin
                bus.ram_owner = OwnMem;
                if (we_q) begin
                    // Release the write strobe one cycle early so data is
                    // held past the rising edge of we_n.
                    bus.ram_we_n = !(OneCycleAcc || !last);
                end else begin
                    bus.ram_oe_n = 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pipe_sched.sv
// Bench for pipe_sched: three instances (ACC_CYCLES = 2, 3, 1) share the
// same stimulus. A directed table exercises the ACC_CYCLES=2 instance, a few
// hand sequences cover store strobes and asynchronous reset, and a random
// phase compares every instance with an access-level reference model.
module tb_pipe_sched;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic if_r = 1'b0, mem_r = 1'b0, we_r = 1'b0, lu_r = 1'b0;

    always #5 clk = ~clk;

    pipe_sched_if b0 ();
    pipe_sched_if b1 ();
    pipe_sched_if b2 ();

    assign b0.if_req = if_r;  assign b0.mem_req = mem_r;
    assign b0.mem_we = we_r;  assign b0.load_use = lu_r;
    assign b1.if_req = if_r;  assign b1.mem_req = mem_r;
    assign b1.mem_we = we_r;  assign b1.load_use = lu_r;
    assign b2.if_req = if_r;  assign b2.mem_req = mem_r;
    assign b2.mem_we = we_r;  assign b2.load_use = lu_r;

    pipe_sched #(.ACC_CYCLES(2)) u0 (.clk(clk), .rst(rst), .bus(b0));
    pipe_sched #(.ACC_CYCLES(3)) u1 (.clk(clk), .rst(rst), .bus(b1));
    pipe_sched #(.ACC_CYCLES(1)) u2 (.clk(clk), .rst(rst), .bus(b2));

    // {pause[4:0], bubble, owner, oe_n, we_n, busy}
    logic [9:0] dut_out [3];
    assign dut_out[0] = {b0.pause, b0.bubble_id_ex, b0.ram_owner, b0.ram_oe_n, b0.ram_we_n, b0.busy};
    assign dut_out[1] = {b1.pause, b1.bubble_id_ex, b1.ram_owner, b1.ram_oe_n, b1.ram_we_n, b1.busy};
    assign dut_out[2] = {b2.pause, b2.bubble_id_ex, b2.ram_owner, b2.ram_oe_n, b2.ram_we_n, b2.busy};

    localparam logic [9:0] IdleOut = 10'b11111_0_0_1_1_0;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: current access kind (0 none, 1 data, 2 fetch) and the
    // cycles left in it, counted down from the access length.
    int ac [3] = '{2, 3, 1};
    int kind [3];
    int rem [3];
    bit md [3];
    bit wq [3];
    int we_low [3];
    int oe_store [3];

    task automatic chk(input string nm, input int k, input logic [9:0] act, input logic [9:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s inst%0d t=%0t: got %b required %b", nm, k, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            kind[k] = 0; rem[k] = 0; md[k] = 0; wq[k] = 0;
        end
    endtask

    function automatic logic [9:0] model_out(input int k);
        logic [4:0] p;
        logic bub, own, oe_n, we_n, bsy;
        bit fin;
        fin  = (kind[k] != 0) && (rem[k] == 1);
        p    = 5'b11111;
        bub  = 1'b0;
        if (kind[k] == 2 && fin) begin
            p   = lu_r ? 5'b00011 : 5'b00000;
            bub = lu_r;
        end
        own  = (kind[k] == 1);
        oe_n = !((kind[k] == 2) || (kind[k] == 1 && !wq[k]));
        we_n = !((kind[k] == 1) && wq[k] && (ac[k] == 1 || rem[k] > 1));
        bsy  = (kind[k] != 0);
        return {p, bub, own, oe_n, we_n, bsy};
    endfunction

    task automatic model_update();
        for (int k = 0; k < 3; k++) begin
            bit md_old;
            md_old = md[k];
            if (kind[k] == 0 || rem[k] == 1) begin
                if (kind[k] == 1) md[k] = 1'b1;
                if (kind[k] == 2) md[k] = 1'b0;
                if (mem_r && !md_old && kind[k] != 1) begin
                    kind[k] = 1; rem[k] = ac[k]; wq[k] = we_r;
                end else if (if_r) begin
                    kind[k] = 2; rem[k] = ac[k];
                end else begin
                    kind[k] = 0; rem[k] = 0;
                end
            end else begin
                rem[k] = rem[k] - 1;
            end
        end
    endtask

    // One clock: compare mid-cycle, then advance the model with the edge.
    task automatic tick(input bit has_exp, input logic [9:0] exp, input string nm);
        @(negedge clk);
        if (has_exp) chk(nm, 0, dut_out[0], exp);
        for (int k = 0; k < 3; k++) begin
            chk("model", k, dut_out[k], model_out(k));
            if (dut_out[k][1] == 1'b0) we_low[k]++;
            if (dut_out[k][3] == 1'b1 && dut_out[k][2] == 1'b0) oe_store[k]++;
        end
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) chk("reset_async", k, dut_out[k], IdleOut);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) chk("reset_hold", k, dut_out[k], IdleOut);
        rst = 1'b1;
        @(posedge clk);
        model_update();
        #1;
    endtask

    typedef struct {
        bit         i, m, w, l;
        logic [9:0] exp;
    } vec_t;

    vec_t tbl [18];

    initial begin
        // inputs {if, mem, we, lu} and ACC_CYCLES=2 outputs
        tbl[0]  = '{1, 0, 0, 0, 10'b11111_0_0_1_1_0};
        tbl[1]  = '{1, 0, 0, 0, 10'b11111_0_0_0_1_1};
        tbl[2]  = '{1, 0, 0, 0, 10'b00000_0_0_0_1_1};
        tbl[3]  = '{1, 0, 0, 1, 10'b11111_0_0_0_1_1};
        tbl[4]  = '{1, 1, 0, 1, 10'b00011_1_0_0_1_1};
        tbl[5]  = '{1, 1, 0, 0, 10'b11111_0_1_0_1_1};
        tbl[6]  = '{1, 1, 0, 0, 10'b11111_0_1_0_1_1};
        tbl[7]  = '{1, 1, 0, 0, 10'b11111_0_0_0_1_1};
        tbl[8]  = '{1, 1, 0, 0, 10'b00000_0_0_0_1_1};
        tbl[9]  = '{1, 1, 1, 0, 10'b11111_0_0_0_1_1};
        tbl[10] = '{1, 1, 1, 0, 10'b00000_0_0_0_1_1};
        tbl[11] = '{1, 1, 1, 0, 10'b11111_0_1_1_0_1};
        tbl[12] = '{1, 1, 1, 0, 10'b11111_0_1_1_1_1};
        tbl[13] = '{1, 0, 0, 0, 10'b11111_0_0_0_1_1};
        tbl[14] = '{0, 0, 0, 0, 10'b00000_0_0_0_1_1};
        tbl[15] = '{0, 0, 0, 0, 10'b11111_0_0_1_1_0};
        tbl[16] = '{1, 0, 0, 0, 10'b11111_0_0_1_1_0};
        tbl[17] = '{1, 0, 0, 0, 10'b11111_0_0_0_1_1};

        #2;
        do_reset();

        // Directed table on the ACC_CYCLES=2 instance
        for (int i = 0; i < 18; i++) begin
            if_r = tbl[i].i; mem_r = tbl[i].m; we_r = tbl[i].w; lu_r = tbl[i].l;
            tick(1'b1, tbl[i].exp, $sformatf("table_row%0d", i));
        end

        // Store strobe length for each access length
        if_r = 0; mem_r = 0; we_r = 0; lu_r = 0;
        do_reset();
        for (int k = 0; k < 3; k++) begin we_low[k] = 0; oe_store[k] = 0; end
        if_r = 1; mem_r = 1; we_r = 1;
        tick(1'b0, '0, "");
        mem_r = 0; we_r = 0;
        for (int c = 0; c < 8; c++) tick(1'b0, '0, "");
        chk("store_we_len", 0, 10'(we_low[0]), 10'd1);
        chk("store_we_len", 1, 10'(we_low[1]), 10'd2);
        chk("store_we_len", 2, 10'(we_low[2]), 10'd1);
        for (int k = 0; k < 3; k++) chk("store_no_oe", k, 10'(oe_store[k]), 10'd0);

        // Reset asserted in the middle of a store (cnt=1 with ACC_CYCLES=3)
        if_r = 0; mem_r = 0; we_r = 0;
        do_reset();
        if_r = 1; mem_r = 1; we_r = 1;
        tick(1'b0, '0, "");
        mem_r = 0; we_r = 0;
        tick(1'b0, '0, "");
        chk("store_mid_we", 1, {9'd0, dut_out[1][1]}, 10'd0);
        do_reset();
        for (int c = 0; c < 5; c++) tick(1'b0, '0, "");

        // Random traffic against the reference model
        for (int c = 0; c < 500; c++) begin
            if_r  = ($urandom_range(0, 9) != 0);
            mem_r = ($urandom_range(0, 9) < 3);
            we_r  = $urandom_range(0, 1);
            lu_r  = ($urandom_range(0, 9) < 3);
            if (c == 250) begin
                do_reset();
            end
            tick(1'b0, '0, "");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_sched.md
# pipe_sched

Pipeline step scheduler and shared-RAM arbiter for the five-stage 16-bit CPU. The single SRAM serves both instruction fetch (IF) and the MEM stage, so this block runs one RAM access at a time (MEM first, then IF), freezes the pipeline while accesses are in flight, and advances all stage registers together once the fetch completes. It also resolves load-use hazards by holding PC and IF/ID and inserting a bubble into ID/EX. It drives the `pause` inputs of `pc_reg`, `if_id`, `id_ex`, `ex_mem` and `mem_wb`, and the RAM control strobes.

## Interface
- `ACC_CYCLES`, default 2: cycles per SRAM access; legal range 1..7.
- `clk` in 1: system clock; all state on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `if_req` in 1: PC is valid and a fetch is wanted.
- `mem_req` in 1: the instruction in MEM needs RAM (load or store).
- `mem_we` in 1: with `mem_req`, 1 means store and 0 means load.
- `load_use` in 1: the ID instruction reads the destination of a load now in EX.
- `pause` out 5: per-stage hold; bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB. 1 means hold.
- `bubble_id_ex` out 1: ID/EX loads the nop instruction (16'h0800) instead of the ID output.
- `ram_owner` out 1: 0 means IF drives the RAM address/data, 1 means MEM drives them.
- `ram_oe_n` out 1: RAM output enable, active-low.
- `ram_we_n` out 1: RAM write enable, active-low.
- `busy` out 1: an access is in progress (state is not IDLE).

## Operation
- States:
  - IDLE: no access.
  - ACC_MEM: data access.
  - ACC_IF: instruction fetch.
- `cnt` (3 bits) counts 0..ACC_CYCLES-1 within an access. `last` = (`cnt` == ACC_CYCLES-1) and state is not IDLE.
- `mem_done` flag: set when an ACC_MEM access ends; cleared on every pipeline advance.
- Arbitration runs in IDLE and on every `last` cycle. The next state is chosen in this order:
  - ACC_MEM if `mem_req` & ~`mem_done` and the current access is not itself ACC_MEM.
  - otherwise ACC_IF if `if_req`.
  - otherwise IDLE.
  - `cnt` resets to 0 on every transition.
- `mem_we` is latched into `we_q` when ACC_MEM is entered.
- Advance cycle = state ACC_IF and `last`. Every other cycle (IDLE, all of ACC_MEM, non-last ACC_IF) drives `pause` = 5'b11111 and `bubble_id_ex` = 0.
- On an advance cycle:
  - Without `load_use`: `pause` = 5'b00000, `bubble_id_ex` = 0.
  - With `load_use`: `pause` = 5'b00011, `bubble_id_ex` = 1. PC and IF/ID hold, ID/EX takes the nop, EX/MEM and MEM/WB advance. The fetched word is discarded and refetched on the next step.
- `ram_owner` = 1 exactly in ACC_MEM.
- `ram_oe_n` = 0 in ACC_IF, and in ACC_MEM when `we_q` = 0.
- `ram_we_n` = 0 in ACC_MEM when `we_q` = 1:
  - If ACC_CYCLES > 1: only while ~`last` (one-cycle data hold).
  - If ACC_CYCLES = 1: for the whole single cycle.
- Outputs are combinational from state, `cnt`, `we_q` and `load_use` only. There is no path from `if_req` or `mem_req` to any output.

## Timing
- Reset values:
  - state IDLE, `cnt` 0, `mem_done` 0, `we_q` 0.
  - Outputs: `pause` 5'b11111, `bubble_id_ex` 0, `ram_owner` 0, `ram_oe_n` 1, `ram_we_n` 1, `busy` 0.
- Reset asserted mid-access aborts the access immediately; no write strobe survives reset.
- Step length:
  - No memory instruction: ACC_CYCLES cycles.
  - Memory instruction: 2·ACC_CYCLES cycles.
  - One extra cycle only when leaving IDLE.
- Simultaneous `mem_req` and `if_req`: MEM always wins; IF follows directly with no idle gap.
- `mem_req` held after its access completes (`mem_done` = 1) is ignored until the next advance.
- `if_req` low on a `last` cycle, with no MEM work pending: go to IDLE; the pipeline stays frozen.
- `load_use` is sampled only on advance cycles; a hazard asserted during a freeze has no effect until the advance.

## Structure
- `defines.v` additions:
  - Pause bit positions (`PausePc` … `PauseMemWb`).
  - State encodings `SchIdle`, `SchAccMem`, `SchAccIf`.
  - Owner codes `OwnIf`/`OwnMem`.
  - `NopIns` 16'h0800.
  - Active-low reset constant `RstnEnable` 1'b0.
- One natural sub-module: `acc_timer`. It holds `cnt`, takes clear and run inputs, and outputs `last`.
- FSM, `mem_done`, `we_q` and the output decode stay in `pipe_sched`.

## Test plan
- Reset, then release with `if_req`=1, `mem_req`=0, ACC_CYCLES=2 → one IDLE cycle; then `pause`=11111 and 00000 alternating; `ram_oe_n`=0 and `ram_owner`=0 throughout ACC_IF.
- `mem_req`=1, `mem_we`=0 at an advance → next step: 2 cycles of ACC_MEM (`ram_owner`=1, `ram_oe_n`=0), then 2 of ACC_IF. `pause`=11111 for 3 cycles, then 00000; no second MEM access.
- Store with ACC_CYCLES=3 → `ram_we_n` low for exactly 2 cycles, `ram_oe_n`=1 throughout. With ACC_CYCLES=1 → `ram_we_n` low for exactly 1 cycle.
- `load_use`=1 on an advance cycle → `pause`=00011 and `bubble_id_ex`=1 for that cycle only. `load_use`=1 during freeze cycles → no effect.
- `rst` pulsed low in cnt=1 of a store → `ram_we_n`=1 and `pause`=11111 asynchronously; after release, restart from IDLE.
- `if_req` dropped on a `last` cycle → state IDLE, `busy`=0, `pause` stays 11111. Raised again → ACC_IF starts next cycle.
